// File: rtl/apu_pkg.sv
// Shared constants for the APU pulse channels: register slot decode,
// channel identity, length-counter lookup and duty waveforms.
package apu_pkg;

  typedef enum logic [1:0] {
    SLOT_CTRL     = 2'd0,
    SLOT_SWEEP    = 2'd1,
    SLOT_TIMER_LO = 2'd2,
    SLOT_TIMER_HI = 2'd3
  } slot_e;

  localparam int CH_PULSE1 = 0;
  localparam int CH_PULSE2 = 1;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // Bit n of each entry is the output level during sequencer step n.
  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b0000_0010,
    8'b0000_0110,
    8'b0001_1110,
    8'b1111_1001
  };

endpackage

// File: rtl/pulse_sweep.sv
// Sweep unit for one pulse channel: owns the 11-bit timer period, the sweep
// divider, the target adder and the mute decision.
module pulse_sweep
  import apu_pkg::*;
#(
  parameter int CH_ID = CH_PULSE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sweep_clk,
  input  logic        write,
  input  logic [1:0]  addr,
  input  logic [7:0]  data,
  output logic [10:0] period,
  output logic        mute
);

  logic        en_q, en_d;
  logic [2:0]  div_period_q, div_period_d;
  logic        negate_q, negate_d;
  logic [2:0]  shift_q, shift_d;
  logic        reload_q, reload_d;
  logic [2:0]  div_q, div_d;
  logic [10:0] period_q, period_d;
  logic [11:0] delta;
  logic [11:0] target;

  // Pulse 1 negates in ones' complement, so it lands one lower than pulse 2.
  always_comb begin
    delta = {1'b0, period_q} >> shift_q;
    if (negate_q) begin
      target = {1'b0, period_q} - delta;
      if (CH_ID == CH_PULSE1) begin
        target = target - 12'd1;
      end
    end else begin
      target = {1'b0, period_q} + delta;
    end
  end

  assign mute   = (period_q < 11'd8) || (!negate_q && target[11]);
  assign period = period_q;

  always_comb begin
    en_d         = en_q;
    div_period_d = div_period_q;
    negate_d     = negate_q;
    shift_d      = shift_q;
    reload_d     = reload_q;
    div_d        = div_q;
    period_d     = period_q;

    if (sweep_clk) begin
      if (div_q == 3'd0 && en_q && shift_q != 3'd0 && !mute) begin
        period_d = target[10:0];
      end
      if (div_q == 3'd0 || reload_q) begin
        div_d    = div_period_q;
        reload_d = 1'b0;
      end else begin
        div_d = div_q - 3'd1;
      end
    end

    // CPU writes are applied last so they override a same-cycle sweep update.
    if (write) begin
      case (addr)
        SLOT_SWEEP: begin
          en_d         = data[7];
          div_period_d = data[6:4];
          negate_d     = data[3];
          shift_d      = data[2:0];
          reload_d     = 1'b1;
        end
        SLOT_TIMER_LO: period_d = {period_q[10:8], data};
        SLOT_TIMER_HI: period_d = {data[2:0], period_q[7:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q         <= 1'b0;
      div_period_q <= '0;
      negate_q     <= 1'b0;
      shift_q      <= '0;
      reload_q     <= 1'b0;
      div_q        <= '0;
      period_q     <= '0;
    end else begin
      en_q         <= en_d;
      div_period_q <= div_period_d;
      negate_q     <= negate_d;
      shift_q      <= shift_d;
      reload_q     <= reload_d;
      div_q        <= div_d;
      period_q     <= period_d;
    end
  end

endmodule

// File: rtl/pulse_channel_param.sv
// Parametrised APU pulse channel (timer, duty sequencer, envelope, length,
// sweep). Define PULSE_SWEEP_EN to include the sweep unit.
module pulse_channel_param
  import apu_pkg::*;
#(
  parameter int CH_ID = CH_PULSE1,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic             iApu_tick,
  input  logic             iEnvelope_clk,
  input  logic             iLength_clk,
  input  logic             iSweep_clk,
  input  logic             iWrite,
  input  logic [1:0]       iAddr,
  input  logic [7:0]       iData,
  input  logic             iEnable,
  output logic [OUT_W-1:0] oPulse,
  output logic             oLength_active
);

  logic [10:0] period;
  logic        mute;

`ifdef PULSE_SWEEP_EN
  pulse_sweep #(
    .CH_ID(CH_ID)
  ) u_sweep (
    .clk       (clk),
    .reset     (iReset),
    .sweep_clk (iSweep_clk),
    .write     (iWrite),
    .addr      (iAddr),
    .data      (iData),
    .period    (period),
    .mute      (mute)
  );
`else
  logic [10:0] period_q, period_d;
  logic        unused_sweep_cfg;

  assign unused_sweep_cfg = iSweep_clk ^ (CH_ID == CH_PULSE1);

  always_comb begin
    period_d = period_q;
    if (iWrite && iAddr == SLOT_TIMER_LO) begin
      period_d = {period_q[10:8], iData};
    end else if (iWrite && iAddr == SLOT_TIMER_HI) begin
      period_d = {iData[2:0], period_q[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  assign period = period_q;
  assign mute   = (period_q < 11'd8);
`endif

  logic [1:0]       duty_q, duty_d;
  logic             halt_q, halt_d;
  logic             const_vol_q, const_vol_d;
  logic [3:0]       vol_q, vol_d;
  logic [10:0]      timer_q, timer_d;
  logic [2:0]       step_q, step_d;
  logic             env_start_q, env_start_d;
  logic [3:0]       decay_q, decay_d;
  logic [3:0]       env_div_q, env_div_d;
  logic [7:0]       length_q, length_d;
  logic [OUT_W-1:0] pulse_q, pulse_d;
  logic             length_active_q, length_active_d;
  logic [7:0]       duty_pattern;
  logic             duty_bit;
  logic [3:0]       volume;
  logic             slot3_write;

  assign slot3_write  = iWrite && (iAddr == SLOT_TIMER_HI);
  assign duty_pattern = DUTY_TABLE[duty_q];
  assign duty_bit     = duty_pattern[step_q];
  assign volume       = const_vol_q ? vol_q : decay_q;

  always_comb begin
    duty_d          = duty_q;
    halt_d          = halt_q;
    const_vol_d     = const_vol_q;
    vol_d           = vol_q;
    timer_d         = timer_q;
    step_d          = step_q;
    env_start_d     = env_start_q;
    decay_d         = decay_q;
    env_div_d       = env_div_q;
    length_d        = length_q;

    if (iWrite && iAddr == SLOT_CTRL) begin
      duty_d      = iData[7:6];
      halt_d      = iData[5];
      const_vol_d = iData[4];
      vol_d       = iData[3:0];
    end

    if (iApu_tick) begin
      if (timer_q == 11'd0) begin
        timer_d = period;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q - 11'd1;
      end
    end

    if (iEnvelope_clk) begin
      if (env_start_q) begin
        env_start_d = 1'b0;
        decay_d     = 4'd15;
        env_div_d   = vol_q;
      end else if (env_div_q == 4'd0) begin
        env_div_d = vol_q;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (halt_q) begin
          decay_d = 4'd15;
        end
      end else begin
        env_div_d = env_div_q - 4'd1;
      end
    end

    if (iLength_clk && !halt_q && length_q != 8'd0) begin
      length_d = length_q - 8'd1;
    end

    // A slot 3 write restarts the note; it beats any same-cycle length clock.
    if (slot3_write) begin
      step_d      = 3'd0;
      env_start_d = 1'b1;
      length_d    = LEN_TABLE[iData[7:3]];
    end

    if (!iEnable) begin
      length_d = 8'd0;
    end

    length_active_d = (length_q != 8'd0);
    if (duty_bit && length_q != 8'd0 && !mute) begin
      pulse_d = OUT_W'(volume) << (OUT_W - 4);
    end else begin
      pulse_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      duty_q          <= '0;
      halt_q          <= 1'b0;
      const_vol_q     <= 1'b0;
      vol_q           <= '0;
      timer_q         <= '0;
      step_q          <= '0;
      env_start_q     <= 1'b0;
      decay_q         <= '0;
      env_div_q       <= '0;
      length_q        <= '0;
      pulse_q         <= '0;
      length_active_q <= 1'b0;
    end else begin
      duty_q          <= duty_d;
      halt_q          <= halt_d;
      const_vol_q     <= const_vol_d;
      vol_q           <= vol_d;
      timer_q         <= timer_d;
      step_q          <= step_d;
      env_start_q     <= env_start_d;
      decay_q         <= decay_d;
      env_div_q       <= env_div_d;
      length_q        <= length_d;
      pulse_q         <= pulse_d;
      length_active_q <= length_active_d;
    end
  end

  assign oPulse         = pulse_q;
  assign oLength_active = length_active_q;

endmodule

// File: tb/tb_pulse_channel_param.sv
// Directed bench for pulse_channel_param: pulse 1 (4-bit out) and pulse 2
// (6-bit out) instances share every input.
module tb_pulse_channel_param;

  logic       clk = 1'b0;
  logic       iReset = 1'b0;
  logic       iApu_tick = 1'b0;
  logic       iEnvelope_clk = 1'b0;
  logic       iLength_clk = 1'b0;
  logic       iSweep_clk = 1'b0;
  logic       iWrite = 1'b0;
  logic [1:0] iAddr = 2'd0;
  logic [7:0] iData = 8'd0;
  logic       iEnable = 1'b0;
  logic [3:0] pulse1;
  logic [5:0] pulse2;
  logic       la1;
  logic       la2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_channel_param #(.CH_ID(0), .OUT_W(4)) dut1 (
    .clk(clk), .iReset(iReset), .iApu_tick(iApu_tick),
    .iEnvelope_clk(iEnvelope_clk), .iLength_clk(iLength_clk),
    .iSweep_clk(iSweep_clk), .iWrite(iWrite), .iAddr(iAddr),
    .iData(iData), .iEnable(iEnable), .oPulse(pulse1),
    .oLength_active(la1)
  );

  pulse_channel_param #(.CH_ID(1), .OUT_W(6)) dut2 (
    .clk(clk), .iReset(iReset), .iApu_tick(iApu_tick),
    .iEnvelope_clk(iEnvelope_clk), .iLength_clk(iLength_clk),
    .iSweep_clk(iSweep_clk), .iWrite(iWrite), .iAddr(iAddr),
    .iData(iData), .iEnable(iEnable), .oPulse(pulse2),
    .oLength_active(la2)
  );

  function automatic bit is_high(input int which);
    return (which == 0) ? (pulse1 != 4'd0) : (pulse2 != 6'd0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    iReset = 1'b1;
    iApu_tick = 1'b0;
    iEnvelope_clk = 1'b0;
    iLength_clk = 1'b0;
    iSweep_clk = 1'b0;
    iWrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    iReset = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    iWrite = 1'b1;
    iAddr = addr;
    iData = data;
    @(negedge clk);
    iWrite = 1'b0;
  endtask

  task automatic setup_note(input logic [7:0] ctrl, input logic [7:0] lo, input logic [7:0] hi);
    iEnable = 1'b1;
    write_reg(2'd0, ctrl);
    write_reg(2'd2, lo);
    write_reg(2'd3, hi);
  endtask

  task automatic wait_for(input int which, input bit hi, input int bound, output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    while (k < bound) begin
      if (is_high(which) == hi) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic count_run(input int which, input bit hi, input int bound, output int n);
    n = 0;
    while (is_high(which) == hi && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic measure_high(input int which, input int bound, output int n, output bit ok);
    bit ok0;
    bit ok1;
    n = 0;
    wait_for(which, 1'b0, bound, ok0);
    wait_for(which, 1'b1, bound, ok1);
    ok = ok0 && ok1;
    if (ok) count_run(which, 1'b1, bound, n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pulse1 !== 4'd0) begin errors++; $display("[TB] FAIL reset_pulse1: got %0d expected 0", pulse1); end
    checks++;
    if (pulse2 !== 6'd0) begin errors++; $display("[TB] FAIL reset_pulse2: got %0d expected 0", pulse2); end
    checks++;
    if (la1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_len1: got %b expected 0", la1); end
    checks++;
    if (la2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_len2: got %b expected 0", la2); end
  endtask

  task automatic test_duty();
    bit ok0;
    bit ok1;
    int n;
    do_reset();
    setup_note(8'hBF, 8'h08, 8'h08);
    iApu_tick = 1'b1;
    @(negedge clk);
    checks++;
    if (la1 !== 1'b1) begin errors++; $display("[TB] FAIL duty_len_active: got %b expected 1", la1); end
    wait_for(0, 1'b0, 200, ok0);
    wait_for(0, 1'b1, 200, ok1);
    checks++;
    if (!(ok0 && ok1) || pulse1 !== 4'd15) begin
      errors++; $display("[TB] FAIL duty_amp1: got %0d expected 15 (edge_ok=%b)", pulse1, ok0 && ok1);
    end
    checks++;
    if (pulse2 !== 6'd60) begin errors++; $display("[TB] FAIL duty_amp2: got %0d expected 60", pulse2); end
    count_run(0, 1'b1, 200, n);
    checks++;
    if (n != 36) begin errors++; $display("[TB] FAIL duty_high_run: got %0d expected 36", n); end
    count_run(0, 1'b0, 200, n);
    checks++;
    if (n != 36) begin errors++; $display("[TB] FAIL duty_low_run: got %0d expected 36", n); end
    iApu_tick = 1'b0;
  endtask

  task automatic test_length();
    bit seen;
    do_reset();
    setup_note(8'h9F, 8'h08, 8'h08);
    @(negedge clk);
    checks++;
    if (la1 !== 1'b1) begin errors++; $display("[TB] FAIL len_loaded: got %b expected 1", la1); end
    for (int i = 1; i <= 254; i++) begin
      iLength_clk = 1'b1;
      @(negedge clk);
      iLength_clk = 1'b0;
      @(negedge clk);
      if (i == 253) begin
        checks++;
        if (la1 !== 1'b1) begin errors++; $display("[TB] FAIL len_253: got %b expected 1", la1); end
      end
      if (i == 254) begin
        checks++;
        if (la1 !== 1'b0) begin errors++; $display("[TB] FAIL len_254: got %b expected 0", la1); end
      end
    end
    iApu_tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (pulse1 != 4'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL len_silent: got nonzero=%b expected 0", seen); end
    iApu_tick = 1'b0;
  endtask

  task automatic test_envelope();
    int k;
    int expv;
    do_reset();
    setup_note(8'hC2, 8'h08, 8'h08);
    @(negedge clk);
    checks++;
    if (pulse1 !== 4'd0) begin errors++; $display("[TB] FAIL env_start: got %0d expected 0", pulse1); end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        write_reg(2'd0, 8'hE2);
        write_reg(2'd3, 8'h08);
      end
      for (int n = 1; n <= 52; n++) begin
        iEnvelope_clk = 1'b1;
        @(negedge clk);
        iEnvelope_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        k = (n - 1) / 3;
        if (pass == 1) expv = 15 - (k % 16);
        else expv = (k >= 15) ? 0 : 15 - k;
        checks++;
        if (pulse1 !== 4'(expv)) begin
          errors++; $display("[TB] FAIL env_decay loop=%0d n=%0d: got %0d expected %0d", pass, n, pulse1, expv);
        end
        checks++;
        if (pulse2 !== 6'(expv * 4)) begin
          errors++; $display("[TB] FAIL env_decay2 loop=%0d n=%0d: got %0d expected %0d", pass, n, pulse2, expv * 4);
        end
      end
    end
  endtask

`ifdef PULSE_SWEEP_EN
  task automatic test_sweep();
    int n;
    bit ok;
    do_reset();
    setup_note(8'h1F, 8'h00, 8'h09);
    write_reg(2'd1, 8'h89);
    @(negedge clk);
    iSweep_clk = 1'b1;
    @(negedge clk);
    iSweep_clk = 1'b0;
    iApu_tick = 1'b1;
    measure_high(0, 2500, n, ok);
    checks++;
    if (!ok || n != 128) begin errors++; $display("[TB] FAIL sweep_neg_ch0: got run %0d expected 128 (ok=%b)", n, ok); end
    measure_high(1, 2500, n, ok);
    checks++;
    if (!ok || n != 129) begin errors++; $display("[TB] FAIL sweep_neg_ch1: got run %0d expected 129 (ok=%b)", n, ok); end
    iApu_tick = 1'b0;
  endtask

  task automatic test_mute();
    int n;
    bit ok;
    bit seen;
    do_reset();
    setup_note(8'h1F, 8'hF0, 8'h0F);
    write_reg(2'd1, 8'h81);
    iApu_tick = 1'b1;
    @(negedge clk);
    iSweep_clk = 1'b1;
    @(negedge clk);
    iSweep_clk = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4500; i++) begin
      @(negedge clk);
      if (pulse1 != 4'd0 || pulse2 != 6'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL mute_overflow: got nonzero=%b expected 0", seen); end
    write_reg(2'd1, 8'h09);
    write_reg(2'd3, 8'h0F);
    measure_high(0, 5000, n, ok);
    checks++;
    if (!ok || n != 2033) begin errors++; $display("[TB] FAIL mute_period_kept: got run %0d expected 2033 (ok=%b)", n, ok); end
    iApu_tick = 1'b0;
  endtask
`else
  task automatic test_sweep_ignored();
    int n;
    bit ok;
    do_reset();
    setup_note(8'h1F, 8'h00, 8'h09);
    write_reg(2'd1, 8'h89);
    @(negedge clk);
    iSweep_clk = 1'b1;
    @(negedge clk);
    iSweep_clk = 1'b0;
    iApu_tick = 1'b1;
    measure_high(0, 2500, n, ok);
    checks++;
    if (!ok || n != 257) begin errors++; $display("[TB] FAIL nosweep_ch0: got run %0d expected 257 (ok=%b)", n, ok); end
    measure_high(1, 2500, n, ok);
    checks++;
    if (!ok || n != 257) begin errors++; $display("[TB] FAIL nosweep_ch1: got run %0d expected 257 (ok=%b)", n, ok); end
    iApu_tick = 1'b0;
  endtask
`endif

  task automatic test_low_period();
    bit seen;
    bit ok;
    do_reset();
    setup_note(8'hBF, 8'h07, 8'h08);
    iApu_tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pulse1 != 4'd0 || pulse2 != 6'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL mute_period7: got nonzero=%b expected 0", seen); end
    checks++;
    if (la1 !== 1'b1) begin errors++; $display("[TB] FAIL mute_period7_len: got %b expected 1", la1); end
    write_reg(2'd2, 8'h08);
    wait_for(0, 1'b1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL period8_audible: got silent expected pulse within 200 cycles"); end
    iApu_tick = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    iEnable = 1'b1;
    write_reg(2'd0, 8'h9F);
    write_reg(2'd2, 8'h08);
    @(negedge clk);
    iWrite = 1'b1;
    iAddr = 2'd3;
    iData = 8'h00;
    iLength_clk = 1'b1;
    @(negedge clk);
    iWrite = 1'b0;
    iLength_clk = 1'b0;
    @(negedge clk);
    iLength_clk = 1'b1;
    repeat (9) @(negedge clk);
    iLength_clk = 1'b0;
    @(negedge clk);
    checks++;
    if (la1 !== 1'b1) begin errors++; $display("[TB] FAIL collision_after9: got %b expected 1", la1); end
    iLength_clk = 1'b1;
    @(negedge clk);
    iLength_clk = 1'b0;
    @(negedge clk);
    checks++;
    if (la1 !== 1'b0) begin errors++; $display("[TB] FAIL collision_after10: got %b expected 0", la1); end
  endtask

  task automatic test_enable();
    do_reset();
    iEnable = 1'b0;
    write_reg(2'd0, 8'h9F);
    write_reg(2'd2, 8'h08);
    write_reg(2'd3, 8'h08);
    @(negedge clk);
    checks++;
    if (la1 !== 1'b0) begin errors++; $display("[TB] FAIL enable_off_load: got %b expected 0", la1); end
    iEnable = 1'b1;
    write_reg(2'd3, 8'h08);
    @(negedge clk);
    checks++;
    if (la1 !== 1'b1) begin errors++; $display("[TB] FAIL enable_on_load: got %b expected 1", la1); end
    iEnable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (la1 !== 1'b0) begin errors++; $display("[TB] FAIL enable_clear: got %b expected 0", la1); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    do_reset();
    setup_note(8'hBF, 8'h08, 8'h08);
    iApu_tick = 1'b1;
    wait_for(0, 1'b1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rst_mid_pre: got silent expected pulse"); end
    iReset = 1'b1;
    @(negedge clk);
    iReset = 1'b0;
    checks++;
    if (pulse1 !== 4'd0 || la1 !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_out: got pulse=%0d len=%b expected 0 0", pulse1, la1);
    end
    write_reg(2'd3, 8'h08);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pulse1 != 4'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("[TB] FAIL rst_mid_cleared: got nonzero=%b expected 0", seen); end
    checks++;
    if (la1 !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_len: got %b expected 1", la1); end
    iApu_tick = 1'b0;
  endtask

  initial begin
    #3000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_duty();
    test_length();
    test_envelope();
`ifdef PULSE_SWEEP_EN
    test_sweep();
    test_mute();
`else
    test_sweep_ignored();
`endif
    test_low_period();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_channel_param.md
# pulse_channel_param

Parametrised second-generation APU pulse channel. Owns its four register slots, decodes CPU writes with their side effects, and runs the timer, duty sequencer, envelope, sweep (with mute) and length counter internally. Produces one unsigned volume sample per cycle for the mixer. One instance serves pulse 1 or pulse 2, selected by `CH_ID`.

## Interface
Parameters:
- `CH_ID`, 0: 0 = pulse 1 (ones'-complement sweep negate); 1 = pulse 2 (two's-complement negate).
- `OUT_W`, 4: output width, must be ≥4; sample = volume << (OUT_W-4).

Ports:
- `clk`  in  1  single system clock.
- `iReset`  in  1  reset, synchronous, active-high.
- `iApu_tick`  in  1  one-cycle timer enable (every other CPU cycle).
- `iEnvelope_clk`  in  1  quarter-frame strobe.
- `iLength_clk`  in  1  half-frame strobe, length counter.
- `iSweep_clk`  in  1  half-frame strobe, sweep.
- `iWrite`  in  1  register write strobe.
- `iAddr`  in  2  register slot 0–3.
- `iData`  in  8  write data.
- `iEnable`  in  1  status-register channel enable.
- `oPulse`  out  OUT_W  registered sample.
- `oLength_active`  out  1  length counter ≠ 0.

## Operation
- Slot 0: duty[7:6], loop/halt[5], const_vol[4], vol/period[3:0].
- Slot 1: sweep_en[7], sweep_period[6:4], negate[3], shift[2:0]. A write sets sweep_reload.
- Slot 2: period[7:0].
- Slot 3: length_idx[7:3], period[10:8]. A write loads length = LEN_TABLE[idx] if iEnable=1, resets sequencer step to 0, and sets env_start.
- Timer: 11-bit down-counter, decremented on iApu_tick. On a tick at 0 it reloads with period and step = step+1 mod 8.
- Duty patterns, step 0→7: 00 = 01000000, 01 = 01100000, 10 = 01111000, 11 = 10011111.
- Envelope, on iEnvelope_clk:
  - env_start set: clear it, decay=15, div=vol/period.
  - Else div=0: reload div; decay-- if decay>0, else decay=15 if loop=1.
  - Else div--.
- Length, on iLength_clk: decrement if halt=0 and count≠0. iEnable=0 forces count to 0 every cycle.
- Sweep target, 12-bit: delta = period>>shift.
  - negate=0: target = period+delta.
  - negate=1: target = period−delta, minus 1 more when CH_ID=0.
- Mute = period<8 OR target[11]=1 (with negate=0).
- Sweep, on iSweep_clk:
  - If div=0, sweep_en=1, shift≠0 and not mute: period ← target[10:0].
  - If div=0 or sweep_reload: div ← sweep_period and sweep_reload ← 0. Else div--.
- Volume = const_vol ? vol/period : decay.
- oPulse = 0 if duty bit=0, length=0 or mute. Otherwise oPulse = volume<<(OUT_W-4).
- Simultaneous events:
  - A slot 2/3 write and a sweep period update in the same cycle: the CPU write wins.
  - A slot 3 load and iLength_clk in the same cycle: the load wins, with no decrement.
  - Slot 3 write with iEnable=0: the length counter stays 0.

## Timing
- All state updates at posedge clk.
- oPulse and oLength_active are registered and reflect the state one cycle after the causing edge.
- iReset clears everything: registers, timer, step, decay, dividers, flags, length. After reset oPulse=0 and oLength_active=0.
- A reset mid-operation has the same effect, with no partial state kept.
- Strobes are level-sampled each cycle; a strobe held for N cycles acts N times.

## Configuration
- Macro `PULSE_SWEEP_EN`.
- Defined: full sweep unit as above.
- Undefined: sweep divider and target logic are removed, slot 1 writes are ignored, period changes only via slot 2/3 writes, and mute = period<8.

## Structure
- Package `apu_pkg` holds:
  - `LEN_TABLE`, 32×8 standard NES length values;
  - `DUTY_TABLE`, 4×8;
  - slot address constants;
  - the CH_ID encoding.
- Sub-module `pulse_sweep` contains the divider, target adder, mute and period register. It is instantiated under `PULSE_SWEEP_EN`.

## Test plan
- Duty/timer: reset; slot0=0xBF, slot2=0x08, slot3=0x08, iEnable=1; iApu_tick every cycle → oPulse is a 50% (pattern 10) waveform of amplitude 15, 9 ticks per step; oLength_active=1.
- Length: slot0 halt=0, slot3 idx=1 (LEN_TABLE=254); 254 iLength_clk pulses → oLength_active falls to 0 exactly on the 254th; oPulse=0 thereafter.
- Envelope: slot0=0x02 (decay mode, period 2), slot3 written; 3 iEnvelope_clk per decay step → decay goes 15,14,…,0 then holds (loop=0). Repeat with loop=1 → after 0 it wraps to 15.
- Sweep negate: period=0x100, slot1=0x89 (en, P=0, negate, shift 1) → CH_ID=0 gives 0x07F, CH_ID=1 gives 0x080 after one iSweep_clk.
- Mute: period=0x7F0, slot1=0x81 (no negate) → target 0xBE8 overflows; oPulse=0 and period unchanged. Separately, period=0x007 → oPulse=0.
- Collision and reset: slot3 write on the same cycle as iLength_clk → count equals the table value. iReset mid-waveform → oPulse=0 next cycle and all state zeroed.
